pram_fetch: RTL and testbench

- Parametrised program RAM with a multi-word instruction fetch engine; successor to the fixed 8-bit, 512-entry, 3-byte program memory.
- Sits between the loader (write port) and the CPU control unit (fetch port).
- Memory is single-ported: one access per cycle.
- A fetch reads FETCH_WORDS consecutive words, one per cycle, into a packed instruction register.
- Results are delivered with a valid/ack handshake instead of address-change detection.

---
 rtl/pram_fetch_if.sv | 38 +++
 rtl/pram_fetch.sv | 154 +++++++++++++++
 tb/tb_pram_fetch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pram_fetch_if.sv
// Loader write port and CPU fetch handshake bundle for pram_fetch.
interface pram_fetch_if #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned FETCH_WORDS = 3
);
    localparam int unsigned INSTR_W = FETCH_WORDS * DATA_W;

    // Loader write port
    logic               wre;
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  wdata;

    // Fetch request side
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_ready;

    // Instruction delivery side
    logic               instr_valid;
    logic               instr_ack;
    logic [INSTR_W-1:0] instr_data;
    logic               cmd_start;
    logic               busy;
    logic               fetch_err;

    // Loader/CPU side
    modport master (
        output wre, waddr, wdata, fetch_req, fetch_addr, instr_ack,
        input  fetch_ready, instr_valid, instr_data, cmd_start, busy, fetch_err
    );

    // Program RAM side
    modport slave (
        input  wre, waddr, wdata, fetch_req, fetch_addr, instr_ack,
        output fetch_ready, instr_valid, instr_data, cmd_start, busy, fetch_err
    );
endinterface

// File: rtl/pram_fetch.sv
// Parametrised single-port program RAM with a multi-word instruction fetch
// engine. Loader writes take priority over fetch reads and stall the fetch.
// Optional feature macro: PRAM_BOUNDS_CHECK_EN -- fetches that run past the
// top of memory load zeros instead of wrapping and raise fetch_err.
module pram_fetch #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned FETCH_WORDS = 3
) (
    input  logic        clk,
    input  logic        rst,
    pram_fetch_if.slave bus
);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned IDX_W   = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1;
    localparam int unsigned INSTR_W = FETCH_WORDS * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                ready_q, valid_q, start_q, busy_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   cap_word;

    // Loader write port; ignored while reset is asserted
    always_ff @(posedge clk) begin
        if (!rst && bus.wre) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
    end

    assign rd_data = mem_q[rd_addr];

`ifdef PRAM_BOUNDS_CHECK_EN
    localparam int unsigned SUM_W = ADDR_W + 1;

    logic [SUM_W-1:0] rd_sum;
    logic             rd_oob;
    logic             err_acc_q, err_acc_d;
    logic             err_q;

    // Carry out of the address sum marks a slot beyond the top of memory
    assign rd_sum   = {1'b0, base_q} + SUM_W'(idx_q);
    assign rd_addr  = rd_sum[ADDR_W-1:0];
    assign rd_oob   = rd_sum[SUM_W-1];
    assign cap_word = rd_oob ? '0 : rd_data;

    // Accumulate out-of-range hits over one fetch
    always_comb begin
        err_acc_d = err_acc_q;
        if (state_q == IDLE && bus.fetch_req) begin
            err_acc_d = 1'b0;
        end else if (state_q == READ && !bus.wre) begin
            err_acc_d = err_acc_q | rd_oob;
        end
    end

    // Error flag shown only while the result is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_acc_q <= err_acc_d;
            err_q     <= (state_d == DONE) && err_acc_d;
        end
    end

    assign bus.fetch_err = err_q;
`else
    // Address arithmetic wraps modulo DEPTH
    assign rd_addr       = base_q + ADDR_W'(idx_q);
    assign cap_word      = rd_data;
    assign bus.fetch_err = 1'b0;
`endif

    // Fetch FSM next-state and capture logic
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.fetch_req) begin
                    state_d = READ;
                    base_d  = bus.fetch_addr;
                    idx_d   = '0;
                end
            end
            READ: begin
                // A loader write owns the port this cycle; the fetch stalls
                if (!bus.wre) begin
                    for (int unsigned k = 0; k < FETCH_WORDS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            instr_d[k*DATA_W +: DATA_W] = cap_word;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.instr_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            instr_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            instr_q <= instr_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d == DONE);
            start_q <= (state_d == DONE) && (state_q != DONE);
            busy_q  <= (state_d == READ);
        end
    end

    assign bus.fetch_ready = ready_q;
    assign bus.instr_valid = valid_q;
    assign bus.cmd_start   = start_q;
    assign bus.busy        = busy_q;
    assign bus.instr_data  = instr_q;
endmodule

// File: tb/tb_pram_fetch.sv
// Directed bench for pram_fetch: default-parameter vector table plus a
// single-word-fetch instance for back-to-back throughput.
module tb_pram_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pram_fetch_if #(.DATA_W(8), .ADDR_W(9), .FETCH_WORDS(3)) bus0 ();
    pram_fetch_if #(.DATA_W(16), .ADDR_W(4), .FETCH_WORDS(1)) bus1 ();

    pram_fetch #(.DATA_W(8), .ADDR_W(9), .FETCH_WORDS(3)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pram_fetch #(.DATA_W(16), .ADDR_W(4), .FETCH_WORDS(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

`ifdef PRAM_BOUNDS_CHECK_EN
    localparam logic [4:0]  ERRB = 5'b00001;
    localparam logic [23:0] WRAP = 24'h000011;
`else
    localparam logic [4:0]  ERRB = 5'b00000;
    localparam logic [23:0] WRAP = 24'h332211;
`endif

    // Flags packed as {fetch_ready, instr_valid, cmd_start, busy, fetch_err}
    localparam logic [4:0] F_IDLE  = 5'b10000;
    localparam logic [4:0] F_READ  = 5'b00010;
    localparam logic [4:0] F_DONE1 = 5'b01100;
    localparam logic [4:0] F_DONEH = 5'b01000;

    typedef struct {
        logic        rst;
        logic        wre;
        logic [8:0]  waddr;
        logic [7:0]  wdata;
        logic        req;
        logic [8:0]  faddr;
        logic        ack;
        logic [4:0]  exp_flags;
        logic        chk_data;
        logic [23:0] exp_data;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic w, logic [8:0] wa, logic [7:0] wd,
                                logic rq, logic [8:0] fa, logic ak,
                                logic [4:0] ef, logic cd, logic [23:0] ed);
        vec_t v;
        v.rst = r; v.wre = w; v.waddr = wa; v.wdata = wd;
        v.req = rq; v.faddr = fa; v.ack = ak;
        v.exp_flags = ef; v.chk_data = cd; v.exp_data = ed;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags0();
        return {bus0.fetch_ready, bus0.instr_valid, bus0.cmd_start, bus0.busy, bus0.fetch_err};
    endfunction

    function automatic logic [4:0] flags1();
        return {bus1.fetch_ready, bus1.instr_valid, bus1.cmd_start, bus1.busy, bus1.fetch_err};
    endfunction

    initial begin
        bus0.wre = 1'b0; bus0.waddr = '0; bus0.wdata = '0;
        bus0.fetch_req = 1'b0; bus0.fetch_addr = '0; bus0.instr_ack = 1'b0;
        bus1.wre = 1'b0; bus1.waddr = '0; bus1.wdata = '0;
        bus1.fetch_req = 1'b0; bus1.fetch_addr = '0; bus1.instr_ack = 1'b0;

        // Reset, program load
        vq.push_back(mk(1, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_IDLE,  1, 24'h0));
        vq.push_back(mk(0, 1, 9'h010, 8'hA1, 0, 9'h000, 0, F_IDLE,  0, 24'h0));
        vq.push_back(mk(0, 1, 9'h011, 8'hB2, 0, 9'h000, 0, F_IDLE,  0, 24'h0));
        vq.push_back(mk(0, 1, 9'h012, 8'hC3, 0, 9'h000, 0, F_IDLE,  0, 24'h0));
        vq.push_back(mk(0, 1, 9'h1FF, 8'h11, 0, 9'h000, 0, F_IDLE,  0, 24'h0));
        vq.push_back(mk(0, 1, 9'h000, 8'h22, 0, 9'h000, 0, F_IDLE,  0, 24'h0));
        vq.push_back(mk(0, 1, 9'h001, 8'h33, 0, 9'h000, 0, F_IDLE,  0, 24'h0));
        // Plain fetch of 0x010, consumer holds off five cycles
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 1, 9'h010, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONE1, 1, 24'hC3B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONEH, 1, 24'hC3B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 1, 9'h1FF, 0, F_DONEH, 1, 24'hC3B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONEH, 1, 24'hC3B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONEH, 1, 24'hC3B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONEH, 1, 24'hC3B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 1, F_IDLE,  1, 24'hC3B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 1, F_IDLE,  1, 24'hC3B2A1));
        // Read-after-write: write to slot 2 stalls one cycle and is seen
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 1, 9'h010, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 1, 9'h012, 8'h55, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONE1, 1, 24'h55B2A1));
        // Ack with a simultaneous request: only the ack acts
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 1, 9'h1FF, 1, F_IDLE,  1, 24'h55B2A1));
        // Wrap fetch; late write to an already captured slot is not seen
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 1, 9'h1FF, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 1, 9'h1FF, 8'h77, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONE1 | ERRB, 1, WRAP));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONEH | ERRB, 1, WRAP));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 1, F_IDLE,  1, WRAP));
        // Reset in second READ cycle; write during reset is dropped
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 1, 9'h010, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(1, 1, 9'h010, 8'hEE, 0, 9'h000, 0, F_IDLE,  1, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 1, 9'h010, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_READ,  0, 24'h0));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 0, F_DONE1, 1, 24'h55B2A1));
        vq.push_back(mk(0, 0, 9'h000, 8'h00, 0, 9'h000, 1, F_IDLE,  1, 24'h55B2A1));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst             = vq[i].rst;
            bus0.wre        = vq[i].wre;
            bus0.waddr      = vq[i].waddr;
            bus0.wdata      = vq[i].wdata;
            bus0.fetch_req  = vq[i].req;
            bus0.fetch_addr = vq[i].faddr;
            bus0.instr_ack  = vq[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("v%0d flags", i), 64'(flags0()), 64'(vq[i].exp_flags));
            if (vq[i].chk_data) begin
                check($sformatf("v%0d data", i), 64'(bus0.instr_data), 64'(vq[i].exp_data));
            end
        end

        // Single-word instance: load, then request and ack held high
        @(negedge clk);
        rst = 1'b0;
        bus0.wre = 1'b0; bus0.fetch_req = 1'b0; bus0.instr_ack = 1'b0;
        bus1.wre = 1'b1; bus1.waddr = 4'h3; bus1.wdata = 16'hBEEF;
        @(negedge clk);
        bus1.wre = 1'b0;
        bus1.fetch_req = 1'b1; bus1.fetch_addr = 4'h3; bus1.instr_ack = 1'b1;
        @(posedge clk);
        #1;
        check("w1 accept flags", 64'(flags1()), 64'(F_READ));
        @(posedge clk);
        #1;
        check("w1 latency flags", 64'(flags1()), 64'(F_DONE1));
        check("w1 data", 64'(bus1.instr_data), 64'h0000_0000_0000_BEEF);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            case (c % 3)
                0:       check($sformatf("w1 c%0d flags", c), 64'(flags1()), 64'(F_DONE1));
                1:       check($sformatf("w1 c%0d flags", c), 64'(flags1()), 64'(F_IDLE));
                default: check($sformatf("w1 c%0d flags", c), 64'(flags1()), 64'(F_READ));
            endcase
        end
        check("w1 data hold", 64'(bus1.instr_data), 64'h0000_0000_0000_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
